mult_seq_64: RTL and testbench
==============================

Name: mult_seq_64

Overview:
- Iterative shift-add multiplier producing a 64-bit product for the MUL instruction path.
- Its result feeds the 64-bit enabled register stage directly downstream:
  - product drives that register's d input.
  - done drives its enable.
- One operand bit per cycle; a start/busy/done handshake lets the control unit stall until the result is ready.

Parameters:
WIDTH, 64, operand and product-low width; the counter is $clog2(WIDTH)+1 bits.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low; 0 forces the reset state immediately, independent of clk.
start  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
a  input  WIDTH  multiplicand; captured on the accepting edge.
b  input  WIDTH  multiplier; captured on the accepting edge.
signed_op  input  1  captured with operands; affects only product_hi (optional feature).
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; product is valid from this cycle.
product  output  WIDTH  low WIDTH bits of a*b; held stable until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, done=0, product=0.
  - Internal accumulator, operand shadow registers and counter cleared.
  - Applies mid-operation: any in-flight multiply is abandoned and never produces done.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture a, b, signed_op; accumulator=0; count=0; go RUN. start=0 -> stay IDLE.
  - RUN:
    - Each edge: if multiplier LSB=1, add the shifted multiplicand into the accumulator (2*WIDTH-bit wide, no overflow possible).
    - Multiplicand shifts left 1, multiplier shifts right 1, count increments.
    - On the edge where count reaches WIDTH-1 (the WIDTH-th iteration), go DONE.
    - start is ignored in RUN; operands are not re-captured.
  - DONE: done=1 for exactly this cycle.
    - product = accumulator[WIDTH-1:0], registered so it is stable during and after done.
    - start=1 on this edge -> new capture, go RUN (back-to-back, no idle bubble). Otherwise go IDLE.
- Latency: start accepted at edge E. busy=1 after E through after E+WIDTH-1. After edge E+WIDTH, busy=0 and done=1 for one cycle. Throughput is one multiply per WIDTH+1 cycles.
- product changes only on the transition into DONE. It holds its last value in IDLE and throughout a following RUN.
- Arithmetic:
  - The low WIDTH bits are identical for signed and unsigned operands (two's complement). signed_op therefore never changes product.
  - Wrap-around: bits above WIDTH are discarded from product. Example: (2^63)*2 = 0.
- Operands are changed freely by the source after the accepting edge. Only the captured copies are used.
- Outputs are registered; no combinational path from inputs to any output.

Optional Feature:
Macro MULT_HIGH_EN.
- Defined:
  - Adds output port product_hi (WIDTH, output).
  - product_hi = accumulator[2*WIDTH-1:WIDTH], giving UMULH when signed_op=0 and SMULH when signed_op=1.
  - Signed handling: operands are converted to magnitude on capture, the sign is recorded, and the full 2*WIDTH result is negated on entry to DONE if the signs differ.
  - Updates, resets and holds exactly like product. Latency is unchanged (no extra cycle).
- Not defined:
  - No product_hi port.
  - signed_op is captured but unused.
  - Accumulator upper half is retained only as needed for shifting.
  - Latency and all other behaviour identical.

Test Plan:
- Reset then a=3, b=5, start=1 for 1 cycle -> busy=1 for 64 cycles; done=1 on the 65th cycle after the accepting edge with product=15; product holds 15 in IDLE.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=64'hFFFF_FFFF_FFFF_FFFF -> product=1. With MULT_HIGH_EN:
  - signed_op=0 -> product_hi=64'hFFFF_FFFF_FFFF_FFFE.
  - signed_op=1 -> product_hi=0.
- Start a=7, b=6; pulse start again with a=9, b=9 at cycle 20 -> ignored; done gives product=42; no second done follows.
- start held high through DONE with a=2, b=2 then a=10, b=10 -> product=4, then immediately RUN; 65 cycles later product=100; done never high on consecutive cycles.
- Start a=100, b=100; drive reset=0 between clock edges at cycle 30 -> busy, done and product go 0 immediately. After release with start=0, stays IDLE and done never asserts.
- a=2^63, b=2 -> product=0 (wrap). With MULT_HIGH_EN, signed_op=0 -> product_hi=1; signed a=-3, b=4 -> product=64'hFFFF_FFFF_FFFF_FFF4, product_hi=all ones.

Source files
------------

// File: rtl/mult_seq_64.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, start/busy/done handshake.
// Optional MULT_HIGH_EN adds o_product_hi (UMULH/SMULH) from a 2*WIDTH accumulator.
module mult_seq_64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed_op,
    output logic             o_busy,
    output logic             o_done,
`ifdef MULT_HIGH_EN
    output logic [WIDTH-1:0] o_product_hi,
`endif
    output logic [WIDTH-1:0] o_product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
`ifdef MULT_HIGH_EN
    localparam int unsigned AW = 2 * WIDTH;
`else
    localparam int unsigned AW = WIDTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    logic [AW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_product;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [AW-1:0]    w_addend;
    logic [AW-1:0]    w_acc_sum;
    logic [AW-1:0]    w_result;

    // Operands become magnitudes on capture; low bits of the negated magnitude
    // product equal the two's complement product, so o_product is sign-agnostic.
    assign w_a_neg   = i_signed_op & i_a[WIDTH-1];
    assign w_b_neg   = i_signed_op & i_b[WIDTH-1];
    assign w_a_mag   = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
    assign w_b_mag   = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;
    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    assign w_acc_sum = r_acc + w_addend;
    assign w_result  = r_neg ? (~w_acc_sum + AW'(1)) : w_acc_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture, shift-add iteration, and result register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_neg        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_product    <= '0;
`ifdef MULT_HIGH_EN
            o_product_hi <= '0;
`endif
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_mcand  <= AW'(w_a_mag);
                r_mplier <= w_b_mag;
                r_neg    <= w_a_neg ^ w_b_neg;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == S_RUN) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
            end
            if (w_last) begin
                r_product    <= w_result[WIDTH-1:0];
`ifdef MULT_HIGH_EN
                o_product_hi <= w_result[AW-1:WIDTH];
`endif
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_product;

endmodule

// File: tb/tb_mult_seq_64.sv
// Self-checking bench for mult_seq_64: vector table, random vs. arithmetic model,
// and hand-written handshake/reset sequences. Honours MULT_HIGH_EN if defined.
module tb_mult_seq_64;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [63:0] i_a;
    logic [63:0] i_b;
    logic        i_signed_op;
    logic        o_busy;
    logic        o_done;
    logic [63:0] o_product;
`ifdef MULT_HIGH_EN
    logic [63:0] o_product_hi;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mult_seq_64 #(.WIDTH(64)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_signed_op (i_signed_op),
        .o_busy      (o_busy),
        .o_done      (o_done),
`ifdef MULT_HIGH_EN
        .o_product_hi(o_product_hi),
`endif
        .o_product   (o_product)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic [63:0] exp_lo;
        logic [63:0] exp_hi;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full 128-bit product straight from integer arithmetic.
    function automatic logic [127:0] ref_full(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        if (s) begin
            sa = $signed({{64{a[63]}}, a});
            sb = $signed({{64{b[63]}}, b});
            return 128'(sa * sb);
        end
        return {64'd0, a} * {64'd0, b};
    endfunction

    // Samples from the current point (cycle 1) until done; cyc=0 on timeout.
    task automatic wait_done(output int cyc, output int busy_cnt);
        logic got;
        got = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!got && cyc < 200) begin
            cyc++;
            if (o_done) got = 1'b1;
            else begin
                if (o_busy) busy_cnt++;
                @(posedge i_clk);
                #1;
            end
        end
        if (!got) cyc = 0;
    endtask

    task automatic run_mult(input logic [63:0] a, input logic [63:0] b, input logic s,
                            input string name);
        int cyc;
        int bc;
        i_a = a;
        i_b = b;
        i_signed_op = s;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_a = {$urandom, $urandom};
        i_b = {$urandom, $urandom};
        i_signed_op = ~s;
        wait_done(cyc, bc);
        chk({name, " latency"}, 64'(cyc), 64'd65);
        chk({name, " busy_cycles"}, 64'(bc), 64'd64);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [127:0] full;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rs;
        int          cyc;
        int          bc;
        int          dcount;
        logic        prev_done;

        vecs[0] = '{64'd3, 64'd5, 1'b0, 64'd15, 64'd0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd1, 64'd0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'd2, 1'b0, 64'd0, 64'd1};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{64'd7, 64'd6, 1'b1, 64'd42, 64'd0};
        vecs[6] = '{64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'd0, 64'd0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd0, 64'h4000_0000_0000_0000};

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_a = '0;
        i_b = '0;
        i_signed_op = 1'b0;
        #2;
        chk("reset busy", 64'(o_busy), 64'd0);
        chk("reset done", 64'(o_done), 64'd0);
        chk("reset product", o_product, 64'd0);
`ifdef MULT_HIGH_EN
        chk("reset product_hi", o_product_hi, 64'd0);
`endif
        #20;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // 3*5, then result must hold through IDLE.
        run_mult(64'd3, 64'd5, 1'b0, "first");
        chk("first product", o_product, 64'd15);
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        chk("hold done", 64'(o_done), 64'd0);
        chk("hold busy", 64'(o_busy), 64'd0);
        chk("hold product", o_product, 64'd15);

        foreach (vecs[i]) begin
            run_mult(vecs[i].a, vecs[i].b, vecs[i].s, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d product", i), o_product, vecs[i].exp_lo);
`ifdef MULT_HIGH_EN
            chk($sformatf("vec%0d product_hi", i), o_product_hi, vecs[i].exp_hi);
`endif
        end

        for (int k = 0; k < 20; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            if (k == 3) ra = 64'h8000_0000_0000_0000;
            full = ref_full(ra, rb, rs);
            run_mult(ra, rb, rs, $sformatf("rnd%0d", k));
            chk($sformatf("rnd%0d product", k), o_product, full[63:0]);
`ifdef MULT_HIGH_EN
            chk($sformatf("rnd%0d product_hi", k), o_product_hi, full[127:64]);
`endif
        end
        @(posedge i_clk);
        #1;

        // start pulsed mid-RUN must be ignored.
        i_a = 64'd7;
        i_b = 64'd6;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (19) begin
            @(posedge i_clk);
            #1;
        end
        i_a = 64'd9;
        i_b = 64'd9;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        wait_done(cyc, bc);
        chk("ignore latency", 64'(cyc), 64'd45);
        chk("ignore product", o_product, 64'd42);
        dcount = 0;
        repeat (70) begin
            @(posedge i_clk);
            #1;
            if (o_done) dcount++;
        end
        chk("ignore no second done", 64'(dcount), 64'd0);
        chk("ignore idle busy", 64'(o_busy), 64'd0);

        // Back-to-back: start held through DONE.
        i_a = 64'd2;
        i_b = 64'd2;
        i_signed_op = 1'b0;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_a = 64'd10;
        i_b = 64'd10;
        wait_done(cyc, bc);
        chk("b2b first latency", 64'(cyc), 64'd65);
        chk("b2b first product", o_product, 64'd4);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        chk("b2b no consecutive done", 64'(o_done), 64'd0);
        chk("b2b rerun busy", 64'(o_busy), 64'd1);
        chk("b2b product held in run", o_product, 64'd4);
        wait_done(cyc, bc);
        chk("b2b second latency", 64'(cyc), 64'd65);
        chk("b2b second product", o_product, 64'd100);
        prev_done = o_done;
        @(posedge i_clk);
        #1;
        chk("b2b done single pulse", 64'(prev_done & o_done), 64'd0);
        chk("b2b back to idle", 64'(o_busy), 64'd0);

        // Asynchronous reset mid-operation.
        i_a = 64'd100;
        i_b = 64'd100;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (29) begin
            @(posedge i_clk);
            #1;
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async reset busy", 64'(o_busy), 64'd0);
        chk("async reset done", 64'(o_done), 64'd0);
        chk("async reset product", o_product, 64'd0);
        #3;
        i_rst_n = 1'b1;
        dcount = 0;
        bc = 0;
        repeat (80) begin
            @(posedge i_clk);
            #1;
            if (o_done) dcount++;
            if (o_busy) bc++;
        end
        chk("post reset no done", 64'(dcount), 64'd0);
        chk("post reset no busy", 64'(bc), 64'd0);
        chk("post reset product", o_product, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
